// File: rtl/vout_pkg.sv
// vout_pkg: shared types and constants for the HDMI-out video source.
//   rgb_t        24-bit packed pixel {r, g, b}
//   state_t      source FSM states IDLE / ALIGN / RUN
//   TIM_1080P_*  CEA-861 1080p60 timing, also usable by the receive side
//   BAR_*        colour-bar palette, plus bar_color() to index it left to right
package vout_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int TIM_1080P_H_ACTIVE = 1920;
  localparam int TIM_1080P_H_FP     = 88;
  localparam int TIM_1080P_H_SYNC   = 44;
  localparam int TIM_1080P_H_BP     = 148;
  localparam int TIM_1080P_V_ACTIVE = 1080;
  localparam int TIM_1080P_V_FP     = 4;
  localparam int TIM_1080P_V_SYNC   = 5;
  localparam int TIM_1080P_V_BP     = 36;
  localparam bit TIM_1080P_HS_POL   = 1'b1;
  localparam bit TIM_1080P_VS_POL   = 1'b1;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vout_counter.sv
// vout_counter: horizontal/vertical raster counters and their timing decode.
// Counters start at (0,0) and advance every clock unless clr is high.
// Build option: VOUT_PATTERN_EN exposes the horizontal position for the
// colour-bar generator.
// Ports:
//   clk_i   pixel clock
//   rst_ni  asynchronous active-low reset
//   clr     synchronous clear; holds both counters at 0
//   h_pos   current h count (VOUT_PATTERN_EN only)
//   active  inside the active picture
//   hs      inside the hsync pulse (active-high, polarity applied by the caller)
//   vs      inside the vsync interval, switching on hsync leading edges
//   first   at the first pixel of the frame (0,0)
module vout_counter #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr,
`ifdef VOUT_PATTERN_EN
  output logic [HW-1:0] h_pos,
`endif
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          first
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACTEND = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACTEND = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_prev;
  logic [VW-1:0] vs_line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // v_cnt steps at the line wrap, but vsync must move with the hsync leading
  // edge. Before that edge we are still "on" the previous line for vs purposes.
  assign v_prev  = (v_cnt == '0) ? V_LAST : v_cnt - VW'(1);
  assign vs_line = (h_cnt >= HS_START) ? v_cnt : v_prev;

  assign active = (h_cnt < H_ACTEND) && (v_cnt < V_ACTEND);
  assign hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs     = (vs_line >= VS_START) && (vs_line < VS_END);
  assign first  = (h_cnt == '0) && (v_cnt == '0);

`ifdef VOUT_PATTERN_EN
  assign h_pos = h_cnt;
`endif

endmodule

// File: rtl/vout_timing_gen.sv
// vout_timing_gen: transmit-side video source for the ADV7511 parallel bus.
// Generates hs/vs/de timing, pulls RGB pixels from a valid/ready stream that
// carries a start-of-frame marker, locks the stream to the raster and outputs
// black when the stream underflows or loses alignment.
// Build option: VOUT_PATTERN_EN adds pattern_i, which replaces the stream with
// eight vertical colour bars.
// Ports:
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   en_i           run enable; low returns to IDLE and clears the sticky flags
//   pattern_i      colour-bar select (VOUT_PATTERN_EN only)
//   pix_valid_i    stream valid
//   pix_sof_i      first pixel of a frame, qualified by pix_valid_i
//   pix_data_i     stream pixel {R,G,B}
//   pix_ready_o    stream ready (combinational)
//   vout_hs_o      hsync, registered
//   vout_vs_o      vsync, registered
//   vout_de_o      data enable, registered
//   vout_data_o    pixel data, registered, 0 while de is low
//   frame_start_o  one-cycle pulse with the first pixel of a sof-aligned frame
//   underflow_o    sticky: an active slot had no valid pixel
//   desync_o       sticky: sof marker seen away from (0,0)
//
// state | meaning
// IDLE  | counters held at 0, outputs at reset values, stream not read
// ALIGN | timing running, data black; flush pixels until a sof lands on (0,0)
// RUN   | one stream pixel per active slot; misplaced sof drops back to ALIGN
module vout_timing_gen
  import vout_pkg::*;
#(
  parameter int H_ACTIVE = TIM_1080P_H_ACTIVE,
  parameter int H_FP     = TIM_1080P_H_FP,
  parameter int H_SYNC   = TIM_1080P_H_SYNC,
  parameter int H_BP     = TIM_1080P_H_BP,
  parameter int V_ACTIVE = TIM_1080P_V_ACTIVE,
  parameter int V_FP     = TIM_1080P_V_FP,
  parameter int V_SYNC   = TIM_1080P_V_SYNC,
  parameter int V_BP     = TIM_1080P_V_BP,
  parameter bit HS_POL   = TIM_1080P_HS_POL,
  parameter bit VS_POL   = TIM_1080P_VS_POL
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
`ifdef VOUT_PATTERN_EN
  input  logic        pattern_i,
`endif
  input  logic        pix_valid_i,
  input  logic        pix_sof_i,
  input  logic [23:0] pix_data_i,
  output logic        pix_ready_o,
  output logic        vout_hs_o,
  output logic        vout_vs_o,
  output logic        vout_de_o,
  output logic [23:0] vout_data_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  output logic        desync_o
);

  state_t state;
  logic   active_dec;
  logic   hs_dec;
  logic   vs_dec;
  logic   first_dec;
  logic   cnt_clr;
  logic   misplaced;
  logic   pat_on;

  // The raster only runs outside IDLE; en_i low restarts it at (0,0).
  assign cnt_clr = !en_i || (state == IDLE);

`ifdef VOUT_PATTERN_EN
  localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [HW-1:0] BAR_W_C = HW'(BAR_W);
  localparam logic [HW-1:0] BAR_MAX = HW'(7);

  logic [HW-1:0] h_pos;
  logic [HW-1:0] bar_q;
  logic [2:0]    bar_idx;
  rgb_t          bar_rgb;

  assign pat_on = pattern_i;

  // Any remainder of H_ACTIVE/8 lands in the last (black) bar.
  always_comb begin
    bar_q   = h_pos / BAR_W_C;
    bar_idx = (bar_q > BAR_MAX) ? 3'd7 : bar_q[2:0];
    bar_rgb = bar_color(bar_idx);
  end
`else
  assign pat_on = 1'b0;
`endif

  vout_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (cnt_clr),
`ifdef VOUT_PATTERN_EN
    .h_pos  (h_pos),
`endif
    .active (active_dec),
    .hs     (hs_dec),
    .vs     (vs_dec),
    .first  (first_dec)
  );

  assign misplaced = pix_valid_i && (pix_sof_i != first_dec);

  // ALIGN takes every pixel except a sof that is waiting for (0,0); at (0,0)
  // it takes whatever is there (the sof pixel, or one more non-sof to flush).
  // Gated by en_i so nothing is accepted on the cycle the block shuts down.
  always_comb begin
    pix_ready_o = 1'b0;
    if (en_i && !pat_on) begin
      case (state)
        ALIGN:   pix_ready_o = first_dec || !(pix_valid_i && pix_sof_i);
        RUN:     pix_ready_o = active_dec && !misplaced;
        default: pix_ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      vout_hs_o     <= ~HS_POL;
      vout_vs_o     <= ~VS_POL;
      vout_de_o     <= 1'b0;
      vout_data_o   <= '0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
      desync_o      <= 1'b0;
    end else if (!en_i) begin
      state         <= IDLE;
      vout_hs_o     <= ~HS_POL;
      vout_vs_o     <= ~VS_POL;
      vout_de_o     <= 1'b0;
      vout_data_o   <= '0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
      desync_o      <= 1'b0;
    end else begin
      vout_hs_o     <= hs_dec ? HS_POL : ~HS_POL;
      vout_vs_o     <= vs_dec ? VS_POL : ~VS_POL;
      vout_de_o     <= active_dec;
      vout_data_o   <= '0;
      frame_start_o <= 1'b0;

      case (state)
        IDLE: begin
          state     <= ALIGN;
          vout_hs_o <= ~HS_POL;
          vout_vs_o <= ~VS_POL;
          vout_de_o <= 1'b0;
        end

        ALIGN: begin
          if (!pat_on && first_dec && pix_valid_i && pix_sof_i) begin
            vout_data_o   <= pix_data_i;
            frame_start_o <= 1'b1;
            state         <= RUN;
          end
        end

        RUN: begin
          if (!pat_on && active_dec) begin
            if (!pix_valid_i) begin
              underflow_o <= 1'b1;
            end else if (misplaced) begin
              desync_o <= 1'b1;
              state    <= ALIGN;
            end else begin
              vout_data_o   <= pix_data_i;
              frame_start_o <= first_dec;
            end
          end
        end

        default: state <= IDLE;
      endcase

`ifdef VOUT_PATTERN_EN
      if (pat_on && active_dec && (state != IDLE)) begin
        vout_data_o <= bar_rgb;
      end
`endif
    end
  end

endmodule
